// File: rtl/sram_bridge.sv
// Bridge from a 32-bit word memory port to a 16-bit asynchronous SRAM.
// Each word access runs as up to two half-word phases of WAIT cycles each.
module sram_bridge #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned WAIT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [15:0]       data,
    output logic              wre,
    output logic              oute,
    output logic              hb_mask,
    output logic              lb_mask,
    output logic              chip_en
);

    localparam int unsigned WORD_W = ADDR_W - 1;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               cap_we, cap_we_nx;
    logic [WORD_W-1:0]  cap_word, cap_word_nx;
    logic [31:0]        cap_wdata, cap_wdata_nx;
    logic [3:0]         cap_be, cap_be_nx;
    logic [31:0]        rdata_nx;
    logic               ready_nx, busy_nx;
    logic [ADDR_W-1:0]  addr_nx;
    logic               wre_nx, oute_nx, hb_mask_nx, lb_mask_nx, chip_en_nx;
    logic               drive, drive_nx;
    logic [15:0]        dout, dout_nx;

    // Byte-offset bits of the CPU address carry no meaning for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign data = drive ? dout : 16'bz;

    // Next state plus next value of every registered output.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        cap_we_nx    = cap_we;
        cap_word_nx  = cap_word;
        cap_wdata_nx = cap_wdata;
        cap_be_nx    = cap_be;
        rdata_nx     = rdata;

        case (state)
            IDLE: begin
                if (req) begin
                    cap_we_nx    = we;
                    cap_word_nx  = cpu_addr[ADDR_W:2];
                    cap_wdata_nx = wdata;
                    cap_be_nx    = be;
                    cnt_nx       = '0;
                    if (!we || (be[1:0] != 2'b00)) state_nx = LO;
                    else if (be[3:2] != 2'b00)     state_nx = HI;
                    else                           state_nx = DONE;
                end
            end
            LO: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (!cap_we) rdata_nx[15:0] = data;
                    state_nx = (cap_we && (cap_be[3:2] == 2'b00)) ? DONE : HI;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            HI: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (!cap_we) rdata_nx[31:16] = data;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        ready_nx   = 1'b0;
        busy_nx    = (state_nx != IDLE);
        addr_nx    = addr;
        wre_nx     = 1'b1;
        oute_nx    = 1'b1;
        hb_mask_nx = 1'b1;
        lb_mask_nx = 1'b1;
        chip_en_nx = 1'b1;
        drive_nx   = 1'b0;
        dout_nx    = dout;

        // Strobes follow the state being entered so they are valid for the whole phase.
        case (state_nx)
            LO, HI: begin
                addr_nx    = {cap_word_nx, (state_nx == HI)};
                chip_en_nx = 1'b0;
                if (cap_we_nx) begin
                    wre_nx     = 1'b0;
                    drive_nx   = 1'b1;
                    lb_mask_nx = (state_nx == HI) ? ~cap_be_nx[2] : ~cap_be_nx[0];
                    hb_mask_nx = (state_nx == HI) ? ~cap_be_nx[3] : ~cap_be_nx[1];
                    dout_nx    = (state_nx == HI) ? cap_wdata_nx[31:16] : cap_wdata_nx[15:0];
                end else begin
                    oute_nx    = 1'b0;
                    lb_mask_nx = 1'b0;
                    hb_mask_nx = 1'b0;
                end
            end
            DONE:    ready_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_word  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            addr      <= '0;
            wre       <= 1'b1;
            oute      <= 1'b1;
            hb_mask   <= 1'b1;
            lb_mask   <= 1'b1;
            chip_en   <= 1'b1;
            drive     <= 1'b0;
            dout      <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cap_we    <= cap_we_nx;
            cap_word  <= cap_word_nx;
            cap_wdata <= cap_wdata_nx;
            cap_be    <= cap_be_nx;
            rdata     <= rdata_nx;
            ready     <= ready_nx;
            busy      <= busy_nx;
            addr      <= addr_nx;
            wre       <= wre_nx;
            oute      <= oute_nx;
            hb_mask   <= hb_mask_nx;
            lb_mask   <= lb_mask_nx;
            chip_en   <= chip_en_nx;
            drive     <= drive_nx;
            dout      <= dout_nx;
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Scoreboard bench for sram_bridge: a WAIT=1/ADDR_W=18 and a WAIT=3/ADDR_W=12
// instance, each attached to a behavioural byte-masked async SRAM.
module tb_sram_bridge;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        int          lat;
        int          issue;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Instance A
    logic        req_a = 1'b0, we_a = 1'b0;
    logic [18:0] cpu_addr_a = '0;
    logic [31:0] wdata_a = '0;
    logic [3:0]  be_a = '0;
    logic [31:0] rdata_a;
    logic        ready_a, busy_a, wre_a, oute_a, hb_mask_a, lb_mask_a, chip_en_a;
    logic [17:0] addr_a;
    tri1  [15:0] data_a;
    logic [15:0] mem_a [0:(1<<18)-1];

    // Instance B
    logic        req_b = 1'b0, we_b = 1'b0;
    logic [12:0] cpu_addr_b = '0;
    logic [31:0] wdata_b = '0;
    logic [3:0]  be_b = '0;
    logic [31:0] rdata_b;
    logic        ready_b, busy_b, wre_b, oute_b, hb_mask_b, lb_mask_b, chip_en_b;
    logic [11:0] addr_b;
    tri1  [15:0] data_b;
    logic [15:0] mem_b [0:(1<<12)-1];

    sram_bridge #(.ADDR_W(18), .WAIT(1)) dut_a (
        .clock(clock), .reset(reset), .req(req_a), .we(we_a), .cpu_addr(cpu_addr_a),
        .wdata(wdata_a), .be(be_a), .rdata(rdata_a), .ready(ready_a), .busy(busy_a),
        .addr(addr_a), .data(data_a), .wre(wre_a), .oute(oute_a), .hb_mask(hb_mask_a),
        .lb_mask(lb_mask_a), .chip_en(chip_en_a)
    );

    sram_bridge #(.ADDR_W(12), .WAIT(3)) dut_b (
        .clock(clock), .reset(reset), .req(req_b), .we(we_b), .cpu_addr(cpu_addr_b),
        .wdata(wdata_b), .be(be_b), .rdata(rdata_b), .ready(ready_b), .busy(busy_b),
        .addr(addr_b), .data(data_b), .wre(wre_b), .oute(oute_b), .hb_mask(hb_mask_b),
        .lb_mask(lb_mask_b), .chip_en(chip_en_b)
    );

    // Behavioural SRAMs: drive on read enable, write masked bytes mid-cycle.
    assign data_a = (!chip_en_a && !oute_a) ? mem_a[addr_a] : 16'bz;
    assign data_b = (!chip_en_b && !oute_b) ? mem_b[addr_b] : 16'bz;

    always @(negedge clock) begin
        if (!chip_en_a && !wre_a) begin
            if (!lb_mask_a) mem_a[addr_a][7:0]  <= data_a[7:0];
            if (!hb_mask_a) mem_a[addr_a][15:8] <= data_a[15:8];
        end
        if (!chip_en_b && !wre_b) begin
            if (!lb_mask_b) mem_b[addr_b][7:0]  <= data_b[7:0];
            if (!hb_mask_b) mem_b[addr_b][15:8] <= data_b[15:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input bit sel);
        exp_t e;
        if (sel ? (q_b.size() == 0) : (q_a.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready inst=%0d: got ready=1 expected none pending", sel);
        end else begin
            e = sel ? q_b.pop_front() : q_a.pop_front();
            chk(sel ? "latency_b" : "latency_a", 32'(cyc - e.issue + 1), 32'(e.lat));
            if (e.is_read) chk(sel ? "rdata_b" : "rdata_a", sel ? rdata_b : rdata_a, e.rdata);
        end
    endtask

    // Monitor: every ready pulse consumes one scoreboard entry.
    always @(negedge clock) begin
        if (!reset) begin
            if (ready_a) mon(1'b0);
            if (ready_b) mon(1'b1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic issue(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] b, input int lat, input logic [31:0] exp_rd, input bit hold);
        exp_t e;
        @(negedge clock);
        if (sel) begin
            req_b = 1'b1; we_b = w; cpu_addr_b = 13'(a); wdata_b = wd; be_b = b;
        end else begin
            req_a = 1'b1; we_a = w; cpu_addr_a = 19'(a); wdata_a = wd; be_a = b;
        end
        @(posedge clock);
        #1;
        e.is_read = !w; e.rdata = exp_rd; e.lat = lat; e.issue = cyc;
        if (sel) q_b.push_back(e); else q_a.push_back(e);
        if (!hold) begin
            req_a = 1'b0; req_b = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] snap4, snap5;
        exp_t e;

        repeat (2) @(negedge clock);
        chk("rst_wre", wre_a, 1); chk("rst_oute", oute_a, 1); chk("rst_chip_en", chip_en_a, 1);
        chk("rst_masks", {hb_mask_a, lb_mask_a}, 2'b11); chk("rst_addr", addr_a, 0);
        chk("rst_rdata", rdata_a, 0); chk("rst_ready", ready_a, 0); chk("rst_busy", busy_a, 0);
        chk("rst_data", data_a, 16'hFFFF);
        reset = 1'b0;

        // Reset asserted during the LO phase of a write
        snap4 = mem_a[4]; snap5 = mem_a[5];
        @(negedge clock);
        req_a = 1'b1; we_a = 1'b1; cpu_addr_a = 19'h008; wdata_a = 32'h12345678; be_a = 4'hF;
        @(posedge clock); #1;
        req_a = 1'b0;
        chk("t1_wre_lo", wre_a, 0);
        reset = 1'b1;
        #1;
        chk("t1_wre", wre_a, 1); chk("t1_chip_en", chip_en_a, 1);
        chk("t1_data", data_a, 16'hFFFF); chk("t1_busy", busy_a, 0);
        @(negedge clock); reset = 1'b0;
        step(3);
        chk("t1_mem4", mem_a[4], 32'(snap4)); chk("t1_mem5", mem_a[5], 32'(snap5));

        // Full write, WAIT=1
        issue(0, 1, 32'h008, 32'hDEADBEEF, 4'hF, 3, 0, 0);
        chk("t2_addr_lo", addr_a, 4); chk("t2_wre_lo", wre_a, 0); chk("t2_data_lo", data_a, 16'hBEEF);
        chk("t2_masks", {hb_mask_a, lb_mask_a}, 0); chk("t2_busy1", busy_a, 1);
        step(1);
        chk("t2_addr_hi", addr_a, 5); chk("t2_data_hi", data_a, 16'hDEAD); chk("t2_wre_hi", wre_a, 0);
        step(1);
        chk("t2_ready", ready_a, 1); chk("t2_busy3", busy_a, 1); chk("t2_wre_done", wre_a, 1);
        step(1);
        chk("t2_busy4", busy_a, 0);
        chk("t2_mem4", mem_a[4], 16'hBEEF); chk("t2_mem5", mem_a[5], 16'hDEAD);

        // Full read
        issue(0, 0, 32'h008, 0, 4'h0, 3, 32'hDEADBEEF, 0);
        chk("t3_oute_lo", oute_a, 0); chk("t3_addr_lo", addr_a, 4); chk("t3_wre", wre_a, 1);
        chk("t3_masks", {hb_mask_a, lb_mask_a}, 0);
        step(1);
        chk("t3_oute_hi", oute_a, 0); chk("t3_addr_hi", addr_a, 5);
        step(1);
        chk("t3_oute_done", oute_a, 1);
        step(1);

        // Upper-half-only write skips LO
        issue(0, 1, 32'h008, 32'h00AA0000, 4'b0100, 2, 0, 0);
        chk("t4_addr", addr_a, 5); chk("t4_wre", wre_a, 0);
        chk("t4_masks", {hb_mask_a, lb_mask_a}, 2'b10); chk("t4_data", data_a, 16'h00AA);
        step(2);
        chk("t4_rdata_held", rdata_a, 32'hDEADBEEF);
        issue(0, 0, 32'h008, 0, 4'h0, 3, 32'hDEAABEEF, 0);
        step(3);

        // be == 0 write: straight to DONE with no strobe
        issue(0, 1, 32'h008, 32'hFFFFFFFF, 4'h0, 1, 0, 0);
        chk("t5_chip_en", chip_en_a, 1); chk("t5_wre", wre_a, 1); chk("t5_ready", ready_a, 1);
        step(1);
        chk("t5_mem5", mem_a[5], 16'hDEAA);

        issue(0, 1, 32'h00C, 32'hCAFEF00D, 4'hF, 3, 0, 0);
        step(3);

        // req held high: back-to-back reads four cycles apart
        issue(0, 0, 32'h008, 0, 4'h0, 3, 32'hDEAABEEF, 1);
        cpu_addr_a = 19'h00C;
        e.is_read = 1'b1; e.rdata = 32'hCAFEF00D; e.lat = 3; e.issue = cyc + 4;
        q_a.push_back(e);
        step(4);
        cpu_addr_a = 19'h008;
        e.rdata = 32'hDEAABEEF; e.issue = cyc + 4;
        q_a.push_back(e);
        step(4);
        req_a = 1'b0;
        step(3);

        // WAIT=3, ADDR_W=12: out-of-range address bit truncated
        issue(1, 1, 32'h3FFC, 32'h89ABCDEF, 4'hF, 7, 0, 0);
        chk("t6_addr_lo", addr_b, 12'hFFE); chk("t6_wre_lo", wre_b, 0); chk("t6_data_lo", data_b, 16'hCDEF);
        step(2);
        chk("t6_addr_lo3", addr_b, 12'hFFE); chk("t6_wre_lo3", wre_b, 0);
        step(1);
        chk("t6_addr_hi", addr_b, 12'hFFF); chk("t6_data_hi", data_b, 16'h89AB);
        step(2);
        chk("t6_wre_hi3", wre_b, 0);
        step(1);
        chk("t6_wre_done", wre_b, 1);
        step(1);
        chk("t6_mem_lo", mem_b[12'hFFE], 16'hCDEF); chk("t6_mem_hi", mem_b[12'hFFF], 16'h89AB);

        issue(1, 0, 32'h1FFC, 0, 4'h0, 7, 32'h89ABCDEF, 0);
        chk("t6r_oute_lo", oute_b, 0); chk("t6r_addr_lo", addr_b, 12'hFFE);
        step(2);
        chk("t6r_oute_lo3", oute_b, 0);
        step(1);
        chk("t6r_addr_hi", addr_b, 12'hFFF); chk("t6r_oute_hi", oute_b, 0);
        step(2);
        chk("t6r_oute_hi3", oute_b, 0);
        step(1);
        chk("t6r_oute_done", oute_b, 1);
        step(1);

        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) step(1);
        chk("scoreboard_drained", 32'(q_a.size() + q_b.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
